// File: rtl/btn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_pkg                                                      |
// | Description : Shared types and constants for the button auto-repeat block: |
// |               FSM state enum, timer/count widths, parameter defaults.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package btn_pkg;

  localparam int C_TMR_W          = 26;
  localparam int C_CNT_W          = 8;

  localparam int C_HOLD_DLY_DEF   = 25000000;
  localparam int C_REP_PERIOD_DEF = 5000000;
  localparam int C_ACCEL_CNT_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_timer                                                    |
// | Description : Clearable up counter. terminal is high in the last cycle of  |
// |               a cmp-cycle interval measured from the clear.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_timer
  import btn_pkg::*;
#(
  parameter int WIDTH = C_TMR_W
)(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] cmp,
  output logic             terminal
);

  logic [WIDTH-1:0] r_count;

  // Cycle counter; a clear makes the next cycle read zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Terminal one cycle early so a registered event lands exactly cmp cycles after the clear.
  always_comb begin
    terminal = (r_count == (cmp - WIDTH'(1)));
  end

endmodule
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_repeat                                                   |
// | Description : Button press / auto-repeat / release pulse generator for an  |
// |               active-low debounced button. The release pulse port is       |
// |               named release_pulse because release is a reserved word.      |
// |               Optional macro BTN_REPEAT_ACCEL_EN: repeat period drops to   |
// |               REP_PERIOD>>2 once ACCEL_CNT repeats have occurred.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_repeat
  import btn_pkg::*;
#(
  parameter int HOLD_DLY   = C_HOLD_DLY_DEF,
  parameter int REP_PERIOD = C_REP_PERIOD_DEF,
  parameter int ACCEL_CNT  = C_ACCEL_CNT_DEF
)(
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic press,
  output logic rep,
  output logic release_pulse,
  output logic step,
  output logic held
);

  localparam int                 c_rep_fast_i = ((REP_PERIOD >> 2) < 1) ? 1 : (REP_PERIOD >> 2);
  localparam logic [C_TMR_W-1:0] c_hold       = C_TMR_W'(HOLD_DLY);
  localparam logic [C_TMR_W-1:0] c_rep_slow   = C_TMR_W'(REP_PERIOD);
  localparam logic [C_TMR_W-1:0] c_rep_fast   = C_TMR_W'(c_rep_fast_i);
  localparam logic [C_CNT_W-1:0] c_accel_cnt  = C_CNT_W'(ACCEL_CNT);
`ifdef BTN_REPEAT_ACCEL_EN
  localparam logic               c_accel_on   = 1'b1;
`else
  localparam logic               c_accel_on   = 1'b0;
`endif

  btn_state_t         r_state;
  btn_state_t         w_state_nxt;
  logic               r_prev;
  logic [C_CNT_W-1:0] r_count;
  logic [C_CNT_W-1:0] w_count_nxt;
  logic [C_CNT_W-1:0] w_count_inc;
  logic               r_press;
  logic               r_rep;
  logic               r_rel;
  logic               r_step;
  logic               r_held;
  logic               w_press_nxt;
  logic               w_rep_nxt;
  logic               w_rel_nxt;
  logic               w_press_edge;
  logic               w_tmr_clear;
  logic               w_tmr_term;
  logic [C_TMR_W-1:0] w_tmr_cmp;
  logic [C_TMR_W-1:0] w_period;

  btn_timer #(
    .WIDTH    (C_TMR_W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (w_tmr_clear),
    .cmp      (w_tmr_cmp),
    .terminal (w_tmr_term)
  );

  // Repeat period and timer compare value; only state-derived, so no loop through the timer.
  always_comb begin
    w_period = ((c_accel_on == 1'b1) && (r_count >= c_accel_cnt)) ? c_rep_fast : c_rep_slow;
    w_tmr_cmp = (r_state == REPEAT) ? w_period : c_hold;
  end

  // Next state, next pulse values and saturating repeat count; release beats a due repeat.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_press_nxt  = 1'b0;
    w_rep_nxt    = 1'b0;
    w_rel_nxt    = 1'b0;
    w_tmr_clear  = 1'b0;
    w_press_edge = r_prev & ~btn;
    w_count_inc  = (r_count == '1) ? r_count : (r_count + C_CNT_W'(1));
    case (r_state)
      IDLE: begin
        if (w_press_edge) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
          w_tmr_clear = 1'b1;
          w_count_nxt = '0;
        end
      end
      PRESSED: begin
        if (btn) begin
          w_state_nxt = IDLE;
          w_rel_nxt   = 1'b1;
        end else if (w_tmr_term) begin
          w_state_nxt = REPEAT;
          w_rep_nxt   = 1'b1;
          w_tmr_clear = 1'b1;
          w_count_nxt = w_count_inc;
        end
      end
      REPEAT: begin
        if (btn) begin
          w_state_nxt = IDLE;
          w_rel_nxt   = 1'b1;
        end else if (w_tmr_term) begin
          w_rep_nxt   = 1'b1;
          w_tmr_clear = 1'b1;
          w_count_nxt = w_count_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, edge register, repeat count and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_prev  <= 1'b0;
      r_count <= '0;
      r_press <= 1'b0;
      r_rep   <= 1'b0;
      r_rel   <= 1'b0;
      r_step  <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= btn;
      r_count <= w_count_nxt;
      r_press <= w_press_nxt;
      r_rep   <= w_rep_nxt;
      r_rel   <= w_rel_nxt;
      r_step  <= w_press_nxt | w_rep_nxt;
      r_held  <= (w_state_nxt != IDLE);
    end
  end

  assign press         = r_press;
  assign rep           = r_rep;
  assign release_pulse = r_rel;
  assign step          = r_step;
  assign held          = r_held;

endmodule
`default_nettype wire

// File: doc/btn_repeat.md
BTN_REPEAT -- requirements
Module: btn_repeat

Interface
REQ-001 Parameter HOLD_DLY, default 25000000, cycles from press pulse to first repeat pulse (legal range 2 to 2^26-1).
REQ-002 Parameter REP_PERIOD, default 5000000, cycles between repeat pulses (legal range 4 to 2^26-1).
REQ-003 Parameter ACCEL_CNT, default 8, repeat count after which acceleration applies (legal range 1 to 255; used only with BTN_REPEAT_ACCEL_EN).
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 btn  input  1  debounced button level, active-low (0 = pressed), already synchronous to clock.
REQ-007 press  output  1  one-cycle pulse on a new press.
REQ-008 rep  output  1  one-cycle pulse per auto-repeat.
REQ-009 release  output  1  one-cycle pulse on release.
REQ-010 step  output  1  press OR rep, registered, for value up/down counters.
REQ-011 held  output  1  level, high while the FSM is in PRESSED or REPEAT.

Function
REQ-012 FSM states: IDLE, PRESSED (waiting HOLD_DLY), REPEAT.
REQ-013 Previous-level register prev tracks btn every cycle; a press edge is prev=1 and btn=0.
REQ-014 IDLE -> PRESSED on a press edge; press and step are high in the following cycle T; the 26-bit cycle timer and 8-bit repeat count clear at T.
REQ-015 PRESSED -> REPEAT when the timer reaches HOLD_DLY; the first rep pulse occurs at cycle T+HOLD_DLY.
REQ-016 In REPEAT, subsequent rep pulses occur every REP_PERIOD cycles; the repeat count increments per rep and saturates at 255.
REQ-017 PRESSED or REPEAT -> IDLE when btn is sampled 1; the release pulse occurs in the next cycle R; held is low from R onward.
REQ-018 If release and repeat-terminal coincide: release wins; rep and step stay low in that cycle.
REQ-019 btn low in IDLE without a press edge (prev=0) produces no event.
REQ-020 All outputs are registered; press, rep, release and step are never high for more than one consecutive cycle per event.
REQ-021 press, rep and release are mutually exclusive in any cycle.

Reset
REQ-022 While reset_n=0 at an edge: state=IDLE, timer=0, count=0, prev=0, and press/rep/release/step/held=0 from the next cycle.
REQ-023 prev resets to 0, so a button held through reset release produces no press until it has been released and pressed again.
REQ-024 Reset mid-PRESSED or mid-REPEAT aborts silently, with no release pulse.

Configuration
REQ-025 Macro BTN_REPEAT_ACCEL_EN defined: once the repeat count is at least ACCEL_CNT, the repeat period becomes REP_PERIOD>>2 (minimum 1) until release.
REQ-026 Macro BTN_REPEAT_ACCEL_EN undefined: the period is always REP_PERIOD; ACCEL_CNT is ignored, and the repeat count is still maintained (saturating).

Structure
REQ-027 Package btn_pkg holds the state enum (IDLE/PRESSED/REPEAT), the timer width constant 26, the count width constant 8, and the default parameter constants.
REQ-028 One sub-module, btn_timer: a clearable 26-bit up counter with a compare input and a one-cycle terminal output, instantiated once.
REQ-029 No other sub-modules; the FSM and the edge register live in btn_repeat.

Verification (HOLD_DLY=10, REP_PERIOD=4, ACCEL_CNT=2)
REQ-030 btn 1->0 at cycle 0 and held 3 cycles, then 1 -> press at cycle 1; held high during cycles 1 to 3; release at cycle 4; no rep.
REQ-031 btn low from cycle 0 for 30 cycles -> press at 1; rep at 11, 15, 19, 23, 27; release at 31; step high at 1, 11, 15, 19, 23, 27.
REQ-032 With BTN_REPEAT_ACCEL_EN and btn low for 30 cycles -> rep at 11 and 15, then every cycle from 16 through 30; release at 31.
REQ-033 btn low during reset, reset_n deasserted at cycle 5, btn held to cycle 20, then released and pressed again at cycle 25 -> no press and no release before 25; press at 26.
REQ-034 btn released exactly on the cycle its rep is due (sampled 1 at cycle 14, repeat due at 15) -> release at 15, no rep at 15; reset_n pulsed low mid-REPEAT -> all outputs 0 next cycle and no release pulse.
